pc_unit: RTL and testbench
==========================

# pc_unit

Fetch-stage program counter unit. It sits directly upstream of the IF/ID pipeline register and drives the instruction-memory address and the PC handed to IF/ID. It selects the next PC from sequential, branch, jump, interrupt-vector and exception-return sources, and saves and restores the return address (EPC). It also holds the PC during stalls and parks the core in a halted state until an interrupt or reset.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INT_VECTOR, 32'h0000_0100, interrupt service entry address.
- EPC_DEPTH, 4, EPC stack depth; used only when NESTED_INT_EN is defined.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; downstream cannot accept a new fetch.
- halt  in  1  one-cycle pulse from decode on a halt instruction.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  32  branch destination.
- jump_taken  in  1  unconditional jump.
- jump_target  in  32  jump destination.
- int_req  in  1  level interrupt request; held until int_ack.
- int_en  in  1  global interrupt enable.
- eret  in  1  one-cycle pulse; return from interrupt.
- pc_o  out  32  current fetch address, to instruction memory and IF/ID PC input.
- epc_o  out  32  top-of-stack return address; 0 when the stack is empty.
- int_ack  out  1  one-cycle pulse; interrupt accepted.
- in_isr  out  1  EPC depth is nonzero.
- halted  out  1  unit is in the HALTED state.

## Operation

- States: RUN and HALTED.
- Reset (rst low, asynchronous) produces: pc_o = RESET_PC, epc_o = 0, depth = 0, int_ack = 0, in_isr = 0, halted = 0, state RUN.

Interrupt acceptance condition (acc): int_req & int_en & !stall & depth < limit. The limit is 1 without NESTED_INT_EN, or EPC_DEPTH with it.

Next-PC priority in RUN, highest first:
1. acc: pc ← INT_VECTOR. Push return address: branch_target if branch_taken, else jump_target if jump_taken, else pc_o. Set depth+1 and pulse int_ack.
2. eret with depth > 0: pc ← epc_o, pop, depth−1.
3. eret with depth = 0: ignored; falls through to the rules below.
4. stall: pc, epc and depth held. branch_taken and jump_taken are ignored while stall is high; decode must re-present them.
5. branch_taken: pc ← branch_target. If branch_taken and jump_taken are both high, branch wins.
6. jump_taken: pc ← jump_target.
7. halt: pc held, state → HALTED.
8. Otherwise: pc ← pc_o + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).

Additional rules:
- Any eret that pops (rule 2) wins over simultaneous branch, jump, halt and stall.
- eret and acc in the same cycle: acc wins; eret is dropped.
- In HALTED, pc is held and branch, jump, halt and eret are ignored. Only acc (stall is irrelevant in HALTED) or reset leaves the state. acc pushes pc_o, vectors, and returns to RUN.
- All targets have bits [1:0] forced to 0 before loading.

## Timing

- Every output is registered and updates on the rising edge of clk.
- Redirect latency is 1 cycle: the source asserted in cycle n appears on pc_o in cycle n+1.
- int_ack is high for exactly cycle n+1 after acceptance in cycle n.
- epc_o and in_isr reflect push and pop from cycle n+1.
- halted rises the cycle after the halt pulse. It falls the cycle after acc.
- If reset asserts mid-operation, the stack and state are cleared immediately and no pending interrupt is retained.

## Configuration

- NESTED_INT_EN defined: an EPC stack of EPC_DEPTH entries. Interrupts are accepted while in_isr, up to EPC_DEPTH levels; when the stack is full, int_req is masked.
- NESTED_INT_EN undefined: a single EPC register. int_req is masked whenever in_isr = 1, and EPC_DEPTH is unused.

## Structure

- Shared package `cpu_pkg` holds:
  - the state encoding (RUN, HALTED);
  - the default constants RESET_PC_DEF and INT_VECTOR_DEF;
  - the instruction width of 32.
- One sub-module: `epc_stack`, a LIFO with push, pop, top, depth, full and empty. It degenerates to one register when NESTED_INT_EN is undefined.
- Next-PC selection and the state register live in pc_unit.

## Test plan

- **Reset and sequential fetch:** hold rst low, then release with no other inputs. pc_o must read 0, 4, 8, 12 on successive edges.
- **Branch/jump priority:** at pc 0x20, assert branch_taken with target 0x80 and jump_taken with target 0x40 together. pc_o = 0x80 next cycle. Separately, a branch target of 0x83 must load 0x80.
- **Stall:** at pc 0x10, hold stall for 3 cycles with int_req high. pc_o stays 0x10 and int_ack stays 0. After stall drops, int_ack pulses and pc_o = 0x100.
- **Interrupt and return:** at pc 0x30, assert int_req and int_en. pc_o = 0x100, epc_o = 0x30, in_isr = 1. A later eret gives pc_o = 0x30, in_isr = 0.
- **Halt and wake:** at pc 0x50, pulse halt; halted = 1 and pc_o holds 0x50 for 5 cycles, ignoring a jump to 0x200. Raise int_req: pc_o = 0x100, epc_o = 0x50, halted = 0.
- **Nesting (with NESTED_INT_EN, EPC_DEPTH = 4):** take 4 interrupts. A fifth int_req gets no int_ack. 4 erets unwind epc_o in LIFO order. A fifth eret is ignored and pc advances by 4.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch-stage PC unit:
//   - pc_state_t     : PC unit state encoding (RUN, HALTED)
//   - INSN_W         : instruction / address width (32)
//   - RESET_PC_DEF   : default reset PC
//   - INT_VECTOR_DEF : default interrupt service entry address
//   - NESTED_INT     : 1 when the build is configured for nested interrupts
//   - word_align()   : clears address bits [1:0]
// Build option: macro NESTED_INT_EN selects a multi-entry EPC stack.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int INSN_W = 32;

   localparam logic [INSN_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [INSN_W-1:0] INT_VECTOR_DEF = 32'h0000_0100;

`ifdef NESTED_INT_EN
   localparam bit NESTED_INT = 1'b1;
`else
   localparam bit NESTED_INT = 1'b0;
`endif

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } pc_state_t;

   // Number of EPC entries actually built for a requested depth.
   function automatic int epc_entries(input int depth);
      return NESTED_INT ? depth : 1;
   endfunction

   // Instruction fetch addresses are word aligned.
   function automatic logic [INSN_W-1:0] word_align(input logic [INSN_W-1:0] addr);
      return {addr[INSN_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/epc_stack.sv
// -----------------------------------------------------------------------------
// epc_stack
// LIFO of saved return addresses (EPC). With NESTED_INT_EN defined it holds
// DEPTH entries; otherwise it collapses to a single register.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset (clears all entries)
//   push       in   push push_data (ignored when full)
//   pop        in   pop top entry (ignored when empty; push wins if both)
//   push_data  in   return address to save
//   top        out  top-of-stack entry, 0 when empty
//   depth      out  number of valid entries
//   full       out  depth equals the number of entries
//   empty      out  depth is zero
// -----------------------------------------------------------------------------
module epc_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       push,
   input  logic                                       pop,
   input  logic [INSN_W-1:0]                          push_data,
   output logic [INSN_W-1:0]                          top,
   output logic [$clog2(epc_entries(DEPTH) + 1)-1:0]  depth,
   output logic                                       full,
   output logic                                       empty
);

   localparam int ENTRIES = epc_entries(DEPTH);
   localparam int DW      = $clog2(ENTRIES + 1);

   logic [INSN_W-1:0] entry_r [ENTRIES];
   logic [DW-1:0]     depth_r;
   logic              do_push_s;
   logic              do_pop_s;
   logic [INSN_W-1:0] top_s;

   assign full      = (depth_r == DW'(ENTRIES));
   assign empty     = (depth_r == {DW{1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty & ~push;
   assign depth     = depth_r;
   assign top       = top_s;

   // Entry storage: a push writes the slot directly above the current top.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_r[i] <= {INSN_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (do_push_s && (depth_r == DW'(i))) begin
               entry_r[i] <= push_data;
            end else begin
               entry_r[i] <= entry_r[i];
            end
         end
      end
   end

   // Occupancy counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         depth_r <= {DW{1'b0}};
      end else if (do_push_s) begin
         depth_r <= depth_r + DW'(1'b1);
      end else if (do_pop_s) begin
         depth_r <= depth_r - DW'(1'b1);
      end else begin
         depth_r <= depth_r;
      end
   end

   // Top-of-stack select; stays 0 while empty.
   always_comb begin
      top_s = {INSN_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
         top_s = (depth_r == DW'(i + 1)) ? entry_r[i] : top_s;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter. Selects the next fetch address from interrupt
// vector, exception return, stall hold, branch, jump, halt and sequential
// sources, saves/restores return addresses in an EPC stack, and parks the
// core in HALTED until an interrupt is accepted.
// Build option: NESTED_INT_EN -> EPC stack of EPC_DEPTH entries; undefined ->
// single EPC register, interrupts masked while in_isr.
// Parameters: RESET_PC, INT_VECTOR, EPC_DEPTH.
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-low reset
//   stall          in   hold PC
//   halt           in   halt instruction pulse
//   branch_taken   in   branch resolved taken
//   branch_target  in   branch destination
//   jump_taken     in   unconditional jump
//   jump_target    in   jump destination
//   int_req        in   level interrupt request
//   int_en         in   global interrupt enable
//   eret           in   return-from-interrupt pulse
//   pc_o           out  current fetch address
//   epc_o          out  top-of-stack return address (0 when empty)
//   int_ack        out  interrupt accepted pulse
//   in_isr         out  EPC depth nonzero
//   halted         out  unit is HALTED
// -----------------------------------------------------------------------------
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [INSN_W-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [INSN_W-1:0] INT_VECTOR = INT_VECTOR_DEF,
   parameter int                EPC_DEPTH  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              halt,
   input  logic              branch_taken,
   input  logic [INSN_W-1:0] branch_target,
   input  logic              jump_taken,
   input  logic [INSN_W-1:0] jump_target,
   input  logic              int_req,
   input  logic              int_en,
   input  logic              eret,
   output logic [INSN_W-1:0] pc_o,
   output logic [INSN_W-1:0] epc_o,
   output logic              int_ack,
   output logic              in_isr,
   output logic              halted
);

   localparam int DW = $clog2(epc_entries(EPC_DEPTH) + 1);

   pc_state_t         state_r;
   pc_state_t         state_nxt_s;
   logic [INSN_W-1:0] pc_r;
   logic [INSN_W-1:0] pc_nxt_s;
   logic              int_ack_r;
   logic              int_ack_nxt_s;

   logic              push_s;
   logic              pop_s;
   logic [INSN_W-1:0] push_data_s;
   logic [INSN_W-1:0] top_s;
   logic [DW-1:0]     depth_s;
   logic              full_s;
   logic              empty_s;

   logic              acc_run_s;
   logic              acc_halt_s;

   // A full stack masks int_req; stall only blocks acceptance while running.
   assign acc_halt_s = int_req & int_en & ~full_s;
   assign acc_run_s  = acc_halt_s & ~stall;

   epc_stack #(
      .DEPTH (EPC_DEPTH)
   ) u_epc_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (push_data_s),
      .top       (top_s),
      .depth     (depth_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // State, PC and acknowledge registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= RUN;
         pc_r      <= RESET_PC;
         int_ack_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pc_r      <= pc_nxt_s;
         int_ack_r <= int_ack_nxt_s;
      end
   end

   // Next-PC selection and state transitions, in priority order.
   always_comb begin
      state_nxt_s   = state_r;
      pc_nxt_s      = pc_r;
      int_ack_nxt_s = 1'b0;
      push_s        = 1'b0;
      pop_s         = 1'b0;
      push_data_s   = pc_r;
      case (state_r)
         RUN: begin
            if (acc_run_s) begin
               // The return address is where fetch would have gone next.
               pc_nxt_s      = word_align(INT_VECTOR);
               push_s        = 1'b1;
               int_ack_nxt_s = 1'b1;
               if (branch_taken) begin
                  push_data_s = word_align(branch_target);
               end else if (jump_taken) begin
                  push_data_s = word_align(jump_target);
               end else begin
                  push_data_s = pc_r;
               end
            end else if (eret && !empty_s) begin
               pc_nxt_s = top_s;
               pop_s    = 1'b1;
            end else if (stall) begin
               pc_nxt_s = pc_r;
            end else if (branch_taken) begin
               pc_nxt_s = word_align(branch_target);
            end else if (jump_taken) begin
               pc_nxt_s = word_align(jump_target);
            end else if (halt) begin
               pc_nxt_s    = pc_r;
               state_nxt_s = HALTED;
            end else begin
               pc_nxt_s = pc_r + 32'd4;
            end
         end
         HALTED: begin
            if (acc_halt_s) begin
               pc_nxt_s      = word_align(INT_VECTOR);
               push_s        = 1'b1;
               push_data_s   = pc_r;
               int_ack_nxt_s = 1'b1;
               state_nxt_s   = RUN;
            end else begin
               pc_nxt_s    = pc_r;
               state_nxt_s = HALTED;
            end
         end
         default: begin
            state_nxt_s = RUN;
            pc_nxt_s    = pc_r;
         end
      endcase
   end

   assign pc_o    = pc_r;
   assign epc_o   = top_s;
   assign int_ack = int_ack_r;
   assign in_isr  = (depth_s != {DW{1'b0}});
   assign halted  = (state_r == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
   import cpu_pkg::*;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] INT_VECTOR = 32'h0000_0100;
   localparam int          EPC_DEPTH  = 4;
`ifdef NESTED_INT_EN
   localparam int LIMIT = EPC_DEPTH;
`else
   localparam int LIMIT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall, halt, branch_taken, jump_taken, int_req, int_en, eret;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_o, epc_o;
   logic        int_ack, in_isr, halted;

   pc_unit #(
      .RESET_PC   (RESET_PC),
      .INT_VECTOR (INT_VECTOR),
      .EPC_DEPTH  (EPC_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .halt          (halt),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .int_req       (int_req),
      .int_en        (int_en),
      .eret          (eret),
      .pc_o          (pc_o),
      .epc_o         (epc_o),
      .int_ack       (int_ack),
      .in_isr        (in_isr),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_stk[$];
   bit          m_halted;
   bit          m_ack;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
      int_req = 1'b0; int_en = 1'b0; eret = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0;
   endtask

   task automatic compare_all();
      logic [31:0] exp_epc;
      exp_epc = (m_stk.size() != 0) ? m_stk[$] : 32'h0;
      check_eq("pc_o",    pc_o,           m_pc);
      check_eq("epc_o",   epc_o,          exp_epc);
      check_eq("int_ack", {31'd0, int_ack}, {31'd0, m_ack});
      check_eq("in_isr",  {31'd0, in_isr},  {31'd0, (m_stk.size() != 0)});
      check_eq("halted",  {31'd0, halted},  {31'd0, m_halted});
   endtask

   // One clock of behaviour computed from the current inputs.
   task automatic model_step();
      bit          acc;
      logic [31:0] ret;
      m_ack = 1'b0;
      acc = int_req && int_en && (m_stk.size() < LIMIT) && (m_halted || !stall);
      if (acc) begin
         if (m_halted)          ret = m_pc;
         else if (branch_taken) ret = branch_target;
         else if (jump_taken)   ret = jump_target;
         else                   ret = m_pc;
         m_stk.push_back(ret & 32'hFFFF_FFFC);
         m_pc     = INT_VECTOR & 32'hFFFF_FFFC;
         m_halted = 1'b0;
         m_ack    = 1'b1;
      end else if (m_halted) begin
         m_pc = m_pc;
      end else if (eret && m_stk.size() > 0) begin
         m_pc = m_stk.pop_back();
      end else if (stall) begin
         m_pc = m_pc;
      end else if (branch_taken) begin
         m_pc = branch_target & 32'hFFFF_FFFC;
      end else if (jump_taken) begin
         m_pc = jump_target & 32'hFFFF_FFFC;
      end else if (halt) begin
         m_halted = 1'b1;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      m_pc = RESET_PC; m_stk.delete(); m_halted = 1'b0; m_ack = 1'b0;
      #2;
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      clear_inputs();
      rst = 1'b1;
   endtask

   task automatic goto_pc(input logic [31:0] addr);
      jump_taken = 1'b1; jump_target = addr;
      cyc();
      clear_inputs();
   endtask

   initial begin
      logic [31:0] p0;
      clear_inputs();
      #1;
      // Reset and sequential fetch
      apply_reset();
      check_eq("rst_pc", pc_o, 32'h0);
      cyc(); check_eq("seq_4", pc_o, 32'h4);
      cyc(); check_eq("seq_8", pc_o, 32'h8);
      cyc(); check_eq("seq_12", pc_o, 32'hC);

      // Branch beats jump; target alignment
      goto_pc(32'h20);
      branch_taken = 1'b1; branch_target = 32'h80; jump_taken = 1'b1; jump_target = 32'h40;
      cyc(); clear_inputs();
      check_eq("br_over_jmp", pc_o, 32'h80);
      branch_taken = 1'b1; branch_target = 32'h83;
      cyc(); clear_inputs();
      check_eq("br_align", pc_o, 32'h80);
      jump_taken = 1'b1; jump_target = 32'h1002;
      cyc(); clear_inputs();
      check_eq("jmp_align", pc_o, 32'h1000);

      // Stall holds PC and blocks interrupt acceptance
      goto_pc(32'h10);
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1; int_req = 1'b1; int_en = 1'b1;
         cyc();
         check_eq("stall_pc", pc_o, 32'h10);
         check_eq("stall_ack", {31'd0, int_ack}, 32'h0);
      end
      stall = 1'b0;
      cyc(); clear_inputs();
      check_eq("post_stall_ack", {31'd0, int_ack}, 32'h1);
      check_eq("post_stall_pc", pc_o, 32'h100);
      eret = 1'b1; cyc(); clear_inputs();
      check_eq("stall_ret", pc_o, 32'h10);

      // Interrupt and return
      goto_pc(32'h30);
      int_req = 1'b1; int_en = 1'b1;
      cyc(); clear_inputs();
      check_eq("isr_pc", pc_o, 32'h100);
      check_eq("isr_epc", epc_o, 32'h30);
      check_eq("isr_flag", {31'd0, in_isr}, 32'h1);
      cyc(); cyc();
      eret = 1'b1; cyc(); clear_inputs();
      check_eq("eret_pc", pc_o, 32'h30);
      check_eq("eret_isr", {31'd0, in_isr}, 32'h0);

      // Halt and wake
      goto_pc(32'h50);
      halt = 1'b1; cyc(); clear_inputs();
      check_eq("halt_flag", {31'd0, halted}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         jump_taken = 1'b1; jump_target = 32'h200; eret = (i == 2);
         cyc();
         check_eq("halt_hold", pc_o, 32'h50);
      end
      clear_inputs();
      int_req = 1'b1; int_en = 1'b1; cyc(); clear_inputs();
      check_eq("wake_pc", pc_o, 32'h100);
      check_eq("wake_epc", epc_o, 32'h50);
      check_eq("wake_halted", {31'd0, halted}, 32'h0);
      eret = 1'b1; cyc(); clear_inputs();

      // Nesting up to the limit, masked beyond it, LIFO unwind
      for (int i = 0; i < LIMIT; i++) begin
         goto_pc(32'h1000 + 32'(i) * 32'h40);
         int_req = 1'b1; int_en = 1'b1; cyc(); clear_inputs();
         check_eq("nest_ack", {31'd0, int_ack}, 32'h1);
      end
      int_req = 1'b1; int_en = 1'b1; cyc(); clear_inputs();
      check_eq("full_mask_ack", {31'd0, int_ack}, 32'h0);
      for (int i = LIMIT - 1; i >= 0; i--) begin
         check_eq("unwind_epc", epc_o, 32'h1000 + 32'(i) * 32'h40);
         eret = 1'b1; cyc(); clear_inputs();
         check_eq("unwind_pc", pc_o, 32'h1000 + 32'(i) * 32'h40);
      end
      p0 = pc_o;
      eret = 1'b1; cyc(); clear_inputs();
      check_eq("eret_empty", pc_o, p0 + 32'd4);

      // Asynchronous reset mid-ISR with int_req pending
      goto_pc(32'h60);
      int_req = 1'b1; int_en = 1'b1; cyc();
      int_req = 1'b1;
      apply_reset();
      cyc();
      check_eq("post_rst_pc", pc_o, RESET_PC + 32'd4);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         stall         = ($urandom_range(0, 3) == 0);
         halt          = ($urandom_range(0, 15) == 0);
         branch_taken  = ($urandom_range(0, 3) == 0);
         jump_taken    = ($urandom_range(0, 3) == 0);
         int_req       = ($urandom_range(0, 5) == 0);
         int_en        = ($urandom_range(0, 3) != 0);
         eret          = ($urandom_range(0, 5) == 0);
         branch_target = $urandom & 32'hFFFF_FFFC;
         jump_target   = $urandom & 32'hFFFF_FFFC;
         cyc();
         if (m_halted && m_stk.size() >= LIMIT) apply_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
